// File: rtl/fadsu_pkg.sv
// Shared definitions for the pipelined add/sub: mode encoding, stage count
// and parameter legality used by the elaboration checks.
package fadsu_pkg;

  localparam logic ADD = 1'b1;
  localparam logic SUB = 1'b0;

  function automatic int calc_nst(input int w, input int slice);
    return (slice < 1) ? 1 : (w / slice);
  endfunction

  function automatic bit params_ok(input int w, input int slice);
    return (slice >= 1) && (w >= slice) && ((w % slice) == 0);
  endfunction

endpackage

// File: rtl/fas_slice_reg.sv
// One SLICE-bit add/sub stage with registered sum and carry. Only the top
// stage produces a signed-overflow flag; lower stages hold it at zero.
module fas_slice_reg
  import fadsu_pkg::*;
#(
  parameter int SLICE = 4,
  parameter bit TOP   = 1'b0
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             CE,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  input  logic             con,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             ov
);

  logic [SLICE-1:0] bx;
  logic [SLICE:0]   sum;
  logic             cm;

  always_comb begin
    bx  = (con == SUB) ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {{SLICE{1'b0}}, ci};
    // Carry into the MSB recovered from the MSB sum bit and its operands.
    cm  = a[SLICE-1] ^ bx[SLICE-1] ^ sum[SLICE-1];
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      s  <= '0;
      co <= 1'b0;
      ov <= 1'b0;
    end else if (CE) begin
      s  <= sum[SLICE-1:0];
      co <= sum[SLICE];
      ov <= TOP ? (cm ^ sum[SLICE]) : 1'b0;
    end
  end

endmodule

// File: rtl/fadsu_pipe.sv
// Pipelined W-bit adder/subtractor: carry chain cut into SLICE-bit stages,
// operands skewed into the stages and sums deskewed so S emerges aligned.
module fadsu_pipe
  import fadsu_pkg::*;
#(
  parameter int W     = 8,
  parameter int SLICE = 4
) (
  input  logic         CK,
  input  logic         RSTN,
  input  logic         CE,
  input  logic         VI,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         CI,
  input  logic         CON,
  output logic         VO,
  output logic [W-1:0] S,
  output logic         CO,
  output logic         OVF
);

  localparam int NST = calc_nst(W, SLICE);

  if (!params_ok(W, SLICE)) begin : g_bad_params
    $error("fadsu_pipe: W must be a positive multiple of SLICE");
  end

  // Handshake: no backpressure. Every CE=1 edge captures one slot; VI marks
  // it valid, and VO rises NST CE-cycles later for that same slot. CE=0
  // freezes every slot in place.
  logic [NST-1:0] vq;
  logic [NST-1:0] con_s;
  logic [NST-1:0] cin;
  logic [NST-1:0] car;
  logic [NST-1:0] ovs;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      vq <= '0;
    end else if (CE) begin
      vq[0] <= VI;
      for (int k = 1; k < NST; k++) vq[k] <= vq[k-1];
    end
  end

  assign VO = vq[NST-1];

  for (genvar k = 0; k < NST; k++) begin : g_st
    logic [SLICE-1:0] a_k;
    logic [SLICE-1:0] b_k;
    logic [SLICE-1:0] s_k;

    if (k == 0) begin : g_head
      assign a_k      = A[SLICE-1:0];
      assign b_k      = B[SLICE-1:0];
      assign con_s[0] = CON;
      assign cin[0]   = CI;
    end else begin : g_skew
      // Slice k of the operands waits k cycles so it meets its own carry.
      logic [SLICE-1:0] a_sk [k];
      logic [SLICE-1:0] b_sk [k];
      logic             con_r;

      always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
          for (int j = 0; j < k; j++) begin
            a_sk[j] <= '0;
            b_sk[j] <= '0;
          end
          con_r <= 1'b0;
        end else if (CE) begin
          a_sk[0] <= A[k*SLICE +: SLICE];
          b_sk[0] <= B[k*SLICE +: SLICE];
          for (int j = 1; j < k; j++) begin
            a_sk[j] <= a_sk[j-1];
            b_sk[j] <= b_sk[j-1];
          end
          con_r <= con_s[k-1];
        end
      end

      assign a_k      = a_sk[k-1];
      assign b_k      = b_sk[k-1];
      assign con_s[k] = con_r;
      assign cin[k]   = car[k-1];
    end

    fas_slice_reg #(
      .SLICE (SLICE),
      .TOP   (k == NST-1)
    ) u_slice (
      .CK   (CK),
      .RSTN (RSTN),
      .CE   (CE),
      .a    (a_k),
      .b    (b_k),
      .ci   (cin[k]),
      .con  (con_s[k]),
      .s    (s_k),
      .co   (car[k]),
      .ov   (ovs[k])
    );

    localparam int DSK = NST - 1 - k;

    if (DSK == 0) begin : g_direct
      assign S[k*SLICE +: SLICE] = s_k;
    end else begin : g_deskew
      logic [SLICE-1:0] ds [DSK];

      always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
          for (int j = 0; j < DSK; j++) ds[j] <= '0;
        end else if (CE) begin
          ds[0] <= s_k;
          for (int j = 1; j < DSK; j++) ds[j] <= ds[j-1];
        end
      end

      assign S[k*SLICE +: SLICE] = ds[DSK-1];
    end
  end

  assign CO  = car[NST-1];
  assign OVF = |ovs;

endmodule

// File: tb/tb_fadsu_pipe.sv
// Bench for fadsu_pipe: an 8-bit/4 instance for directed scenarios and a
// 16-bit/4 instance for the random sweep, each with its own expected queue.
module tb_fadsu_pipe;
  import fadsu_pkg::*;

  localparam int NST8  = 2;
  localparam int NST16 = 4;

  logic        CK = 1'b0;
  logic        rstn;
  logic        ce;

  logic        vi8, ci8, con8, vo8, co8, ovf8;
  logic [7:0]  a8, b8, s8;
  logic        vi16, ci16, con16, vo16, co16, ovf16;
  logic [15:0] a16, b16, s16;

  int errors = 0;
  int checks = 0;
  logic ce_hit = 1'b0;

  logic [10:0] exp8_q[$];
  logic [18:0] exp16_q[$];

  always #5 CK = ~CK;

  fadsu_pipe #(.W(8), .SLICE(4)) dut8 (
    .CK(CK), .RSTN(rstn), .CE(ce), .VI(vi8), .A(a8), .B(b8), .CI(ci8),
    .CON(con8), .VO(vo8), .S(s8), .CO(co8), .OVF(ovf8)
  );

  fadsu_pipe #(.W(16), .SLICE(4)) dut16 (
    .CK(CK), .RSTN(rstn), .CE(ce), .VI(vi16), .A(a16), .B(b16), .CI(ci16),
    .CON(con16), .VO(vo16), .S(s16), .CO(co16), .OVF(ovf16)
  );

  // Behavioural (W+1)-bit models: {S, CO, OVF}, OVF from operand/result signs.
  function automatic logic [9:0] model8(input logic [7:0] a, b, input logic ci, con);
    logic [7:0] bx;
    logic [8:0] full;
    bx   = (con == ADD) ? b : ~b;
    full = {1'b0, a} + {1'b0, bx} + {8'd0, ci};
    return {full[7:0], full[8], (a[7] == bx[7]) && (full[7] != a[7])};
  endfunction

  function automatic logic [17:0] model16(input logic [15:0] a, b, input logic ci, con);
    logic [15:0] bx;
    logic [16:0] full;
    bx   = (con == ADD) ? b : ~b;
    full = {1'b0, a} + {1'b0, bx} + {16'd0, ci};
    return {full[15:0], full[16], (a[15] == bx[15]) && (full[15] != a[15])};
  endfunction

  task automatic set8(input logic v, input logic [7:0] a, b, input logic ci, con);
    vi8 = v; a8 = a; b8 = b; ci8 = ci; con8 = con;
  endtask

  task automatic set16(input logic v, input logic [15:0] a, b, input logic ci, con);
    vi16 = v; a16 = a; b16 = b; ci16 = ci; con16 = con;
  endtask

  // Scoreboard: push on every capturing edge, pop once the slot has emerged.
  always @(posedge CK) begin
    ce_hit = rstn && ce;
    if (rstn && ce) begin
      exp8_q.push_back({vi8, model8(a8, b8, ci8, con8)});
      exp16_q.push_back({vi16, model16(a16, b16, ci16, con16)});
    end
  end

  always @(negedge CK) begin
    logic [10:0] e8;
    logic [18:0] e16;
    if (ce_hit) begin
      if (exp8_q.size() >= NST8) begin
        e8 = exp8_q.pop_front();
        checks++;
        if (e8[10] ? ({vo8, s8, co8, ovf8} !== e8) : (vo8 !== 1'b0)) begin
          errors++;
          $display("FAIL sb8: got vo=%b s=%h co=%b ovf=%b, expected vo=%b s=%h co=%b ovf=%b",
                   vo8, s8, co8, ovf8, e8[10], e8[9:2], e8[1], e8[0]);
        end
      end
      if (exp16_q.size() >= NST16) begin
        e16 = exp16_q.pop_front();
        checks++;
        if (e16[18] ? ({vo16, s16, co16, ovf16} !== e16) : (vo16 !== 1'b0)) begin
          errors++;
          $display("FAIL sb16: got vo=%b s=%h co=%b ovf=%b, expected vo=%b s=%h co=%b ovf=%b",
                   vo16, s16, co16, ovf16, e16[18], e16[17:2], e16[1], e16[0]);
        end
      end
    end
  end

  task automatic drain();
    repeat (NST16 + 1) begin
      @(negedge CK);
      ce = 1'b1;
      set8(1'b0, 8'h00, 8'h00, 1'b0, ADD);
      set16(1'b0, 16'h0000, 16'h0000, 1'b0, ADD);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    ce   = 1'b0;
    set8(1'b0, 8'h00, 8'h00, 1'b0, ADD);
    set16(1'b0, 16'h0000, 16'h0000, 1'b0, ADD);
    #1;
    checks++;
    if ({vo8, s8, co8, ovf8, vo16, s16, co16, ovf16} !== '0) begin
      errors++;
      $display("FAIL reset_por: got vo8=%b s8=%h vo16=%b s16=%h, expected all zero", vo8, s8, vo16, s16);
    end
    repeat (2) @(negedge CK);
    rstn = 1'b1;
    ce   = 1'b1;
    set8(1'b1, 8'h12, 8'h34, 1'b0, ADD);
    set16(1'b1, 16'h1234, 16'h4321, 1'b0, ADD);
    @(negedge CK);
    set8(1'b1, 8'hA5, 8'h0F, 1'b1, SUB);
    set16(1'b1, 16'hA5A5, 16'h0F0F, 1'b1, SUB);
    @(negedge CK);
    set8(1'b1, 8'h77, 8'h11, 1'b0, ADD);
    set16(1'b1, 16'h7777, 16'h1111, 1'b0, ADD);
    @(negedge CK);
    #2;
    rstn = 1'b0;
    #1;
    ce_hit = 1'b0;
    exp8_q.delete();
    exp16_q.delete();
    checks++;
    if ({vo8, s8, co8, ovf8, vo16, s16, co16, ovf16} !== '0) begin
      errors++;
      $display("FAIL reset_async: got vo8=%b s8=%h vo16=%b s16=%h, expected all zero", vo8, s8, vo16, s16);
    end
    repeat (2) begin
      @(negedge CK);
      checks++;
      if ({vo8, s8, co8, ovf8, vo16, s16, co16, ovf16} !== '0) begin
        errors++;
        $display("FAIL reset_hold: got vo8=%b s8=%h vo16=%b s16=%h, expected all zero", vo8, s8, vo16, s16);
      end
    end
    rstn = 1'b1;
    set8(1'b0, 8'h00, 8'h00, 1'b0, ADD);
    set16(1'b0, 16'h0000, 16'h0000, 1'b0, ADD);
    repeat (NST16 + 1) begin
      @(negedge CK);
      checks++;
      if ({vo8, vo16} !== 2'b00) begin
        errors++;
        $display("FAIL reset_stale_vo: got vo8=%b vo16=%b, expected 0 0", vo8, vo16);
      end
    end
    drain();
  endtask

  task automatic test_add();
    @(negedge CK);
    set8(1'b1, 8'hFF, 8'h01, 1'b0, ADD);
    @(negedge CK);
    set8(1'b0, 8'h00, 8'h00, 1'b0, ADD);
    @(negedge CK);
    checks++;
    if ({vo8, s8, co8, ovf8} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_carry: got vo=%b s=%h co=%b ovf=%b, expected 1 00 1 0", vo8, s8, co8, ovf8);
    end
    set8(1'b1, 8'h7F, 8'h01, 1'b0, ADD);
    @(negedge CK);
    set8(1'b0, 8'h00, 8'h00, 1'b0, ADD);
    @(negedge CK);
    checks++;
    if ({vo8, s8, co8, ovf8} !== {1'b1, 8'h80, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_ovf: got vo=%b s=%h co=%b ovf=%b, expected 1 80 0 1", vo8, s8, co8, ovf8);
    end
    drain();
  endtask

  task automatic test_sub();
    @(negedge CK);
    set8(1'b1, 8'h00, 8'h01, 1'b1, SUB);
    @(negedge CK);
    set8(1'b0, 8'h00, 8'h00, 1'b0, ADD);
    @(negedge CK);
    checks++;
    if ({vo8, s8, co8, ovf8} !== {1'b1, 8'hFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_borrow: got vo=%b s=%h co=%b ovf=%b, expected 1 ff 0 0", vo8, s8, co8, ovf8);
    end
    set8(1'b1, 8'h80, 8'h01, 1'b1, SUB);
    @(negedge CK);
    set8(1'b0, 8'h00, 8'h00, 1'b0, ADD);
    @(negedge CK);
    checks++;
    if ({vo8, s8, co8, ovf8} !== {1'b1, 8'h7F, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_ovf: got vo=%b s=%h co=%b ovf=%b, expected 1 7f 1 1", vo8, s8, co8, ovf8);
    end
    drain();
  endtask

  task automatic test_stream();
    logic vpat[4];
    vpat = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 14; i++) begin
      @(negedge CK);
      if (i >= 2) begin
        checks++;
        if (vo8 !== vpat[(i-2)%4]) begin
          errors++;
          $display("FAIL stream_vo[%0d]: got %b, expected %b", i - 2, vo8, vpat[(i-2)%4]);
        end
      end
      set8(vpat[i%4], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), (i % 2 == 0) ? ADD : SUB);
      set16(vpat[i%4], 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)), (i % 2 == 0) ? SUB : ADD);
    end
    drain();
  endtask

  task automatic test_stall();
    logic [9:0] mx, my;
    mx = model8(8'hC3, 8'h5A, 1'b1, ADD);
    my = model8(8'h10, 8'h20, 1'b1, SUB);
    @(negedge CK);
    set8(1'b1, 8'hC3, 8'h5A, 1'b1, ADD);
    set16(1'b1, 16'hC3C3, 16'h5A5A, 1'b1, ADD);
    @(negedge CK);
    set8(1'b1, 8'h10, 8'h20, 1'b1, SUB);
    set16(1'b1, 16'h1000, 16'h2000, 1'b1, SUB);
    @(negedge CK);
    ce = 1'b0;
    set8(1'b1, 8'hEE, 8'hEE, 1'b1, ADD);
    set16(1'b1, 16'hEEEE, 16'hEEEE, 1'b1, ADD);
    for (int i = 0; i < 3; i++) begin
      @(negedge CK);
      checks++;
      if ({vo8, s8, co8, ovf8, vo16} !== {1'b1, mx, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got vo=%b s=%h co=%b ovf=%b vo16=%b, expected 1 %h %b %b 0",
                 i, vo8, s8, co8, ovf8, vo16, mx[9:2], mx[1], mx[0]);
      end
    end
    ce = 1'b1;
    set8(1'b0, 8'h00, 8'h00, 1'b0, ADD);
    set16(1'b0, 16'h0000, 16'h0000, 1'b0, ADD);
    @(negedge CK);
    checks++;
    if ({vo8, s8, co8, ovf8} !== {1'b1, my}) begin
      errors++;
      $display("FAIL stall_resume: got vo=%b s=%h co=%b ovf=%b, expected 1 %h %b %b",
               vo8, s8, co8, ovf8, my[9:2], my[1], my[0]);
    end
    drain();
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 10000; i++) begin
      @(negedge CK);
      ce = ($urandom_range(0, 7) != 0);
      set16(1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 65535)),
            16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      set8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_stream();
    test_stall();
    test_sweep();
    @(negedge CK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
